beat_decoder: RTL
=================

BEAT_DECODER -- requirements
Module: beat_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of timing beats per machine cycle (legal range >= 2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the machine-cycle counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port T  input  WIDTH  one-hot beat vector from the timing generator.
REQ-006 SHALL have port beat  output  clog2(WIDTH)  binary index of the last accepted beat.
REQ-007 SHALL have port beat_vld  output  1  beat holds a beat accepted in the previous cycle.
REQ-008 SHALL have port cyc_start  output  1  one-cycle pulse when beat 0 is accepted.
REQ-009 SHALL have port cyc_end  output  1  one-cycle pulse when beat WIDTH-1 is accepted.
REQ-010 SHALL have port cyc_cnt  output  CNT_W  count of completed machine cycles.
REQ-011 SHALL have port err  output  1  sticky sequence-fault flag.
REQ-012 SHALL have port err_cause  output  2  sticky cause bits: [0] not one-hot (zero or multi-hot), [1] out of order.

Function
REQ-013 SHALL sample T on every rising clk edge, with all outputs registered and reflecting that sample one cycle later.
REQ-014 SHALL implement FSM states IDLE, TRACK and FAULT, entering IDLE on reset.
REQ-015 IDLE: T==0 SHALL stay in IDLE with no error; T==1 SHALL go to TRACK with beat=0, beat_vld=1, cyc_start=1; any other one-hot value SHALL go to FAULT setting err_cause[1]; multi-hot SHALL go to FAULT setting err_cause[0].
REQ-016 TRACK: the only legal next sample SHALL be the previous sample rotated left by one (bit WIDTH-1 wraps to bit 0); a legal sample SHALL stay in TRACK with beat=index and beat_vld=1.
REQ-017 cyc_start SHALL assert exactly when beat 0 is accepted, cyc_end exactly when beat WIDTH-1 is accepted, and the two SHALL never assert together.
REQ-018 cyc_cnt SHALL increment by 1 on each accepted beat WIDTH-1, wrapping all-ones to 0 without saturation.
REQ-019 TRACK violation: zero or multi-hot SHALL set err_cause[0]; one-hot but unexpected SHALL set err_cause[1]; either SHALL go to FAULT with err=1 and beat_vld=0.
REQ-020 err and err_cause SHALL be sticky (new causes OR'ed in) and SHALL be cleared only by clr.
REQ-021 FAULT: beat_vld, cyc_start and cyc_end SHALL be 0; beat and cyc_cnt SHALL hold their last values; further bad samples SHALL OR in their causes.
REQ-022 A generator restart seen in TRACK (T returning to 0) SHALL be treated as a violation with err_cause[0].

Reset
REQ-023 While clr=1, without waiting for a clock edge, the block SHALL force state=IDLE, beat=0, beat_vld=0, cyc_start=0, cyc_end=0, cyc_cnt=0, err=0, err_cause=0 and the stored previous sample=0.
REQ-024 clr asserted mid-cycle SHALL abort tracking, and after release the first accepted beat SHALL again be T==1.
REQ-025 Outputs SHALL keep their reset values until the first rising clk after clr deasserts.

Configuration
REQ-026 With BEAT_DECODER_RESYNC_EN defined, T==1 in FAULT SHALL go to TRACK with beat=0, beat_vld=1, cyc_start=1; err and err_cause SHALL be retained and cyc_cnt SHALL continue from its held value.
REQ-027 With BEAT_DECODER_RESYNC_EN undefined, FAULT SHALL be absorbing until clr.

Structure
REQ-028 Package beat_pkg SHALL hold the FSM state enum typedef and the cause-bit index constants ERR_ONEHOT=0 and ERR_ORDER=1.
REQ-029 Sub-module beat_onehot2bin (combinational, parameter WIDTH, outputs binary index plus is-one-hot flag) SHALL be instantiated once on T.

Verification (WIDTH=4, CNT_W=8)
REQ-030 clr pulse, then T=0000,0001,0010,0100,1000,0001 -> beat 0,1,2,3,0 each one cycle later; cyc_start on both beat-0 outputs; cyc_end on beat 3; cyc_cnt=1 after the first 1000.
REQ-031 256 complete beat cycles -> cyc_cnt reads 0x00 after the 256th cyc_end, and err=0 throughout.
REQ-032 In TRACK at 0010, drive 1000 -> err=1, err_cause=2'b10, beat_vld=0, beat holds 1.
REQ-033 In TRACK, drive 0110 then 0000 -> err_cause=2'b01 and remains 01; drive 0100 -> err_cause becomes 2'b11.
REQ-034 After a fault, drive 0001 -> with RESYNC_EN: beat_vld=1, beat=0, cyc_start=1, err stays 1; without: FAULT retained, beat_vld=0.
REQ-035 Assert clr between clk edges in TRACK -> all outputs reset without a clock edge; after release, 0100 in IDLE -> FAULT with err_cause=2'b10.

Source files
------------

// File: rtl/beat_pkg.sv
// Shared types and constants for the beat decoder.
package beat_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      FAULT
   } state_t;

   // Bit positions within err_cause
   localparam int unsigned ERR_ONEHOT = 0;
   localparam int unsigned ERR_ORDER  = 1;

endpackage

// File: rtl/beat_onehot2bin.sv
// Combinational one-hot to binary index converter with a one-hot validity flag.
module beat_onehot2bin #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]         onehot,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     is_onehot
);

   localparam int unsigned IW = $clog2(WIDTH);

   // OR of set-bit positions; only meaningful when is_onehot is high
   always_comb begin
      idx = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (onehot[i]) begin
            idx = idx | i[IW-1:0];
         end
      end
      is_onehot = $onehot(onehot);
   end

endmodule

// File: rtl/beat_decoder.sv
// Decodes a one-hot timing-beat vector into a beat index, cycle markers and a cycle count.
// Define BEAT_DECODER_RESYNC_EN to allow T==1 to resynchronise out of the fault state.
module beat_decoder
   import beat_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [WIDTH-1:0]         T,
   output logic [$clog2(WIDTH)-1:0] beat,
   output logic                     beat_vld,
   output logic                     cyc_start,
   output logic                     cyc_end,
   output logic [CNT_W-1:0]         cyc_cnt,
   output logic                     err,
   output logic [1:0]               err_cause
);

   localparam int unsigned IW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] FIRST_BEAT = WIDTH'(1);
   localparam logic [IW-1:0]    LAST_IDX   = IW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [IW-1:0]    beat_q, beat_d;
   logic             beat_vld_q, beat_vld_d;
   logic             cyc_start_q, cyc_start_d;
   logic             cyc_end_q, cyc_end_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic             err_q, err_d;
   logic [1:0]       cause_q, cause_d;

   logic [IW-1:0]    t_idx;
   logic             t_onehot;
   logic [WIDTH-1:0] expect_t;
   logic [1:0]       bad_cause;
   logic             accept;

   beat_onehot2bin #(
      .WIDTH (WIDTH)
   ) u_onehot2bin (
      .onehot    (T),
      .idx       (t_idx),
      .is_onehot (t_onehot)
   );

   // Only legal successor in TRACK is the previous beat rotated left by one
   assign expect_t = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};

   always_comb begin
      bad_cause = 2'b00;
      if (t_onehot) begin
         bad_cause[ERR_ORDER] = 1'b1;
      end else begin
         bad_cause[ERR_ONEHOT] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      beat_d      = beat_q;
      beat_vld_d  = 1'b0;
      cyc_start_d = 1'b0;
      cyc_end_d   = 1'b0;
      cyc_cnt_d   = cyc_cnt_q;
      cause_d     = cause_q;
      accept      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (T == FIRST_BEAT) begin
               accept = 1'b1;
            end else if (T != '0) begin
               state_d = FAULT;
               cause_d = cause_q | bad_cause;
            end
         end
         TRACK: begin
            if (T == expect_t) begin
               accept = 1'b1;
            end else begin
               state_d = FAULT;
               cause_d = cause_q | bad_cause;
            end
         end
         FAULT: begin
            if (T == FIRST_BEAT) begin
`ifdef BEAT_DECODER_RESYNC_EN
               accept = 1'b1;
`endif
            end else begin
               cause_d = cause_q | bad_cause;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d     = TRACK;
         prev_d      = T;
         beat_d      = t_idx;
         beat_vld_d  = 1'b1;
         cyc_start_d = (t_idx == '0);
         cyc_end_d   = (t_idx == LAST_IDX);
         if (t_idx == LAST_IDX) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
         end
      end

      err_d = |cause_d;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         beat_q      <= '0;
         beat_vld_q  <= 1'b0;
         cyc_start_q <= 1'b0;
         cyc_end_q   <= 1'b0;
         cyc_cnt_q   <= '0;
         err_q       <= 1'b0;
         cause_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         beat_q      <= beat_d;
         beat_vld_q  <= beat_vld_d;
         cyc_start_q <= cyc_start_d;
         cyc_end_q   <= cyc_end_d;
         cyc_cnt_q   <= cyc_cnt_d;
         err_q       <= err_d;
         cause_q     <= cause_d;
      end
   end

   assign beat      = beat_q;
   assign beat_vld  = beat_vld_q;
   assign cyc_start = cyc_start_q;
   assign cyc_end   = cyc_end_q;
   assign cyc_cnt   = cyc_cnt_q;
   assign err       = err_q;
   assign err_cause = cause_q;

endmodule
